reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin write arbiter that lets several requesters share the single write port of one register (RTLReg-style valid/backpressure write request and write response channels). It sits between N upstream write clients and one register instance. Each client sees a private request/response channel pair, and the register sees exactly one transaction at a time. Only one write is outstanding at any time, and each response is routed back to the client that issued the write.

## Interface
Parameters:
- NumPorts, 4: number of requesters; legal range 2..16.
- Width, 8: data width of each write.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_req  input  NumPorts*Width  packed write data; port i occupies bits [i*Width +: Width].
- in_req_valid  input  NumPorts  per-port request valid.
- in_req_bp  output  NumPorts  per-port request backpressure (1 = stall).
- in_resp_valid  output  NumPorts  per-port write-response valid.
- in_resp_bp  input  NumPorts  per-port response backpressure.
- out_req  output  Width  write data to the register.
- out_req_valid  output  1  write request valid to the register.
- out_req_bp  input  1  register request backpressure.
- out_resp_valid  input  1  register write-response valid.
- out_resp_bp  output  1  response backpressure to the register.

## Operation
- Handshakes:
  - A request fires when valid=1 and bp=0 in the same cycle.
  - A response fires when resp_valid=1 and resp_bp=0 in the same cycle.
  - Once a client asserts in_req_valid, it holds valid and data stable until the request fires.
- State registers: state (IDLE, REQ, RESP), grant [clog2(NumPorts)], rr_ptr [clog2(NumPorts)], req_done flag.
- IDLE:
  - Select the first index with in_req_valid=1, scanning rr_ptr, rr_ptr+1, ... with modulo-NumPorts wrap.
  - If one is found, register grant and go to REQ. Otherwise stay in IDLE.
  - Outputs: out_req_valid=0, out_resp_bp=1, all in_req_bp=1, all in_resp_valid=0.
- REQ:
  - out_req = in_req[grant], out_req_valid = in_req_valid[grant].
  - in_req_bp[grant] = out_req_bp; all other in_req_bp=1.
  - Response path active (see below).
  - If the request and the response both fire this cycle, go to IDLE. This is the normal case for the register, whose response is combinational with its request.
  - If only the request fires, set req_done and go to RESP.
  - If in_req_valid[grant] drops before firing (protocol violation), go to IDLE with rr_ptr unchanged.
- RESP: out_req_valid=0 and the response path stays active. Go to IDLE when the response fires.
- Response path (REQ and RESP only):
  - in_resp_valid[grant] = out_resp_valid; other in_resp_valid bits = 0.
  - out_resp_bp = in_resp_bp[grant].
  - A response arriving in REQ before the request has fired is ignored: in_resp_valid is masked to 0 and out_resp_bp=1 until the request fires.
- On completion (response fires), rr_ptr <= (grant+1) mod NumPorts.
- When state is not REQ, out_req = 0.
- Fairness: a client that holds valid is granted within NumPorts transactions.

## Timing
- Reset is synchronous, active-high, and takes priority over all other transitions. On the cycle after reset is sampled high:
  - state=IDLE, rr_ptr=0, grant=0, req_done=0.
  - in_req_bp = all ones, in_resp_valid = 0, out_req_valid=0, out_req=0, out_resp_bp=1.
- Reset mid-transaction abandons the write. The register may or may not have captured the data. No response is delivered to the client.
- Arbitration latency: a request that is valid in IDLE at cycle t appears on out_req_valid at cycle t+1.
- In-request and out-request are combinational pass-throughs while in REQ; no added data latency.
- Throughput against a zero-backpressure register: one write per 2 cycles (IDLE + REQ).
- Backpressure on out_req_bp or in_resp_bp holds the current state indefinitely. The grant never changes until completion or reset.
- Requests arriving while not IDLE wait with in_req_bp=1. They are not lost and not reordered within a port.

## Test plan
- Single port, no backpressure: port 2 writes 0xA5 at cycle 0 -> out_req_valid=1 with out_req=0xA5 at cycle 1; in_resp_valid=4'b0100 at cycle 1; idle at cycle 2; rr_ptr=3.
- All 4 ports valid continuously after reset -> grant order 0,1,2,3,0, each pair of writes 2 cycles apart. Data values 0x10..0x13 appear on out_req in that order.
- Request backpressure: port 1 writes 0x3C; out_req_bp=1 for 3 cycles -> in_req_bp[1]=1 for those cycles, out_req holds 0x3C, and the request fires on cycle 4 with no other port granted meanwhile.
- Split response: out_resp_valid held 0 for 2 cycles after the request fires -> state RESP, out_req_valid=0; then out_resp_valid=1 with in_resp_bp[grant]=1 for 1 cycle -> no completion; completion the next cycle.
- Wrap-around: rr_ptr=3, ports 0 and 3 valid -> port 3 granted first, then port 0.
- Reset asserted in RESP state -> next cycle all outputs equal their reset values. The pending client never sees in_resp_valid, and a subsequent port-0 request is granted normally.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among NumPorts clients.
// One write outstanding at a time; each response is steered back to its issuer.
module reg_write_arbiter #(
  parameter int NumPorts = 4,
  parameter int Width    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumPorts*Width-1:0] in_req,
  input  logic [NumPorts-1:0]       in_req_valid,
  output logic [NumPorts-1:0]       in_req_bp,
  output logic [NumPorts-1:0]       in_resp_valid,
  input  logic [NumPorts-1:0]       in_resp_bp,
  output logic [Width-1:0]          out_req,
  output logic                      out_req_valid,
  input  logic                      out_req_bp,
  input  logic                      out_resp_valid,
  output logic                      out_resp_bp
);

  localparam int GW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [GW:0]   NP   = (GW+1)'(NumPorts);
  localparam logic [GW-1:0] LAST = GW'(NumPorts - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t        r_state, w_state_next;
  logic [GW-1:0] r_grant, w_grant_next;
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_next;
  logic          r_req_done, w_req_done_next;

  // Candidate k of the scan is port (rr_ptr + k) mod NumPorts.
  logic [GW-1:0]       w_rot_idx [NumPorts];
  logic [NumPorts-1:0] w_valid_rot;

  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rot
      logic [GW:0] w_sum;
      assign w_sum           = {1'b0, r_rr_ptr} + (GW+1)'(gi);
      assign w_rot_idx[gi]   = (w_sum >= NP) ? GW'(w_sum - NP) : GW'(w_sum);
      assign w_valid_rot[gi] = in_req_valid[w_rot_idx[gi]];
    end
  endgenerate

  logic          w_found;
  logic [GW-1:0] w_pick;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (w_valid_rot[k]) begin
        w_found = 1'b1;
        w_pick  = w_rot_idx[k];
      end
    end
  end

  logic [Width-1:0] w_sel_data;
  logic             w_grant_valid;
  logic             w_grant_resp_bp;
  logic [GW-1:0]    w_grant_inc;

  assign w_sel_data      = in_req[int'(r_grant)*Width +: Width];
  assign w_grant_valid   = in_req_valid[r_grant];
  assign w_grant_resp_bp = in_resp_bp[r_grant];
  assign w_grant_inc     = (r_grant == LAST) ? '0 : r_grant + 1'b1;

  logic w_req_fire;
  logic w_resp_en;
  logic w_resp_fire;

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_rr_ptr_next   = r_rr_ptr;
    w_req_done_next = r_req_done;
    out_req         = '0;
    out_req_valid   = 1'b0;
    out_resp_bp     = 1'b1;
    in_req_bp       = '1;
    in_resp_valid   = '0;
    w_req_fire      = 1'b0;
    w_resp_en       = 1'b0;
    w_resp_fire     = 1'b0;

    case (r_state)
      S_REQ: begin
        out_req            = w_sel_data;
        out_req_valid      = w_grant_valid;
        in_req_bp[r_grant] = out_req_bp;
        w_req_fire         = w_grant_valid & ~out_req_bp;
        w_resp_en          = r_req_done | w_req_fire;
      end
      S_RESP:  w_resp_en = 1'b1;
      default: ;
    endcase

    // A response is only accepted once the write it answers has been issued.
    if (w_resp_en) begin
      in_resp_valid[r_grant] = out_resp_valid;
      out_resp_bp            = w_grant_resp_bp;
      w_resp_fire            = out_resp_valid & ~w_grant_resp_bp;
    end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_next = w_pick;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (!w_grant_valid) begin
          w_state_next = S_IDLE;
        end else if (w_req_fire) begin
          if (w_resp_fire) begin
            w_state_next    = S_IDLE;
            w_rr_ptr_next   = w_grant_inc;
            w_req_done_next = 1'b0;
          end else begin
            w_state_next    = S_RESP;
            w_req_done_next = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (w_resp_fire) begin
          w_state_next    = S_IDLE;
          w_rr_ptr_next   = w_grant_inc;
          w_req_done_next = 1'b0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_req_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_req_done <= w_req_done_next;
    end
  end

endmodule
